// File: rtl/handshake_elastic_fifo.sv
// rtl/handshake_elastic_fifo.sv - Registered-both-ways elastic FIFO for the handshake datapath
module handshake_elastic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  active;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // active keeps ins_ready low while reset is held and until the first edge after release
    assign ins_ready  = active && (count != FULL_CNT);
    assign outs_valid = (count != '0);
    assign outs       = mem[head];

    assign push = ins_valid && ins_ready;
    assign pop  = outs_valid && outs_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            active <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            active <= 1'b1;
            if (push) begin
                mem[tail] <= ins;
                tail      <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// tb/tb_handshake_elastic_fifo.sv - Directed and randomized checks of handshake_elastic_fifo
module tb_handshake_elastic_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] id   [2];
    logic        iv   [2];
    logic        ordy [2];
    logic        irdy [2];
    logic        ov   [2];
    logic [31:0] od   [2];

    always #5 clk = ~clk;

    handshake_elastic_fifo #(.DATA_WIDTH(32), .NUM_SLOTS(4)) dut4 (
        .clk(clk), .rst(rst),
        .ins(id[0]), .ins_valid(iv[0]), .ins_ready(irdy[0]),
        .outs(od[0]), .outs_valid(ov[0]), .outs_ready(ordy[0])
    );

    handshake_elastic_fifo #(.DATA_WIDTH(32), .NUM_SLOTS(3)) dut3 (
        .clk(clk), .rst(rst),
        .ins(id[1]), .ins_valid(iv[1]), .ins_ready(irdy[1]),
        .outs(od[1]), .outs_valid(ov[1]), .outs_ready(ordy[1])
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          sel   = 0;
    int          cap   = 4;
    bit          active = 1'b0;
    logic [31:0] q    [$];
    logic [31:0] hist [$];
    logic [31:0] rxq  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return active && (q.size() < cap);
    endfunction

    // Empty FIFO shows the slot written cap pushes ago (or the reset value)
    function automatic logic [31:0] model_outs();
        if (q.size() != 0) return q[0];
        if (hist.size() >= cap) return hist[hist.size() - cap];
        return 32'h0;
    endfunction

    task automatic step(input logic v, input logic [31:0] d, input logic r);
        bit push;
        bit pop;
        for (int i = 0; i < 2; i++) begin
            iv[i]   = (i == sel) ? v : 1'b0;
            ordy[i] = (i == sel) ? r : 1'b0;
            id[i]   = d;
        end
        #1;
        check("ins_ready", 32'(irdy[sel]), 32'(model_ready()));
        check("outs_valid", 32'(ov[sel]), 32'(q.size() != 0));
        check("outs", od[sel], model_outs());
        if (ov[sel] && r) rxq.push_back(od[sel]);
        push = v && model_ready();
        pop  = (q.size() != 0) && r;
        @(posedge clk);
        #1;
        if (rst) begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(d);
                hist.push_back(d);
            end
            active = 1'b1;
        end
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b0;
        #1;
        check("rst_ins_ready", 32'(irdy[sel]), 32'h0);
        check("rst_outs_valid", 32'(ov[sel]), 32'h0);
        check("rst_outs", od[sel], 32'h0);
        q.delete();
        hist.delete();
        rxq.delete();
        active = 1'b0;
        step(1'b1, 32'h77, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        bit          v;
        bit          r;
        bit          acc;
        logic [31:0] nv;

        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; id[i] = '0;
        end
        @(posedge clk);
        #1;

        // Streaming from a constant producer
        sel = 0; cap = 4;
        do_reset();
        for (int c = 0; c < 20; c++) step(1'b1, 32'h0000064E, 1'b1);
        check("stream_outs", od[0], 32'h0000064E);
        check("stream_ready", 32'(irdy[0]), 32'h1);

        // Drain, then idle with outs_ready toggling
        for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 1'b1);
        for (int c = 0; c < 5; c++) step(1'b0, 32'h0, 1'(c % 2));
        check("idle_valid", 32'(ov[0]), 32'h0);

        // Backpressure fill of the 4-deep instance
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        nv = 1;
        for (int c = 0; c < 8; c++) begin
            acc = model_ready();
            step(1'b1, nv, 1'b0);
            if (acc && nv < 5) nv++;
        end
        check("bp_full_ready", 32'(irdy[0]), 32'h0);
        check("bp_head", od[0], 32'h1);
        v = 1'b1;
        rxq.delete();
        for (int c = 0; c < 10; c++) begin
            acc = model_ready();
            step(v, 32'h5, 1'b1);
            if (acc) v = 1'b0;
        end
        check("bp_rx_count", rxq.size(), 32'd5);
        for (int i = 0; i < 5 && i < rxq.size(); i++) check("bp_order", rxq[i], 32'(i + 1));

        // Simultaneous push/pop at count 2
        step(1'b1, 32'd10, 1'b0);
        step(1'b1, 32'd11, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b1, 32'(12 + c), 1'b1);
        check("sim_head", od[0], 32'd20);
        check("sim_ready", 32'(irdy[0]), 32'h1);

        // Reset mid-operation, then a lone token
        for (int c = 0; c < 3; c++) step(1'b1, 32'(40 + c), 1'b0);
        do_reset();
        v = 1'b1;
        for (int c = 0; c < 4; c++) begin
            acc = model_ready();
            step(v, 32'hA5, 1'b0);
            if (acc) v = 1'b0;
        end
        rxq.delete();
        for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 1'b1);
        check("rst_rx_count", rxq.size(), 32'd1);
        if (rxq.size() > 0) check("rst_rx_token", rxq[0], 32'hA5);

        // Randomized wrap-around on the 3-deep instance
        sel = 1; cap = 3;
        do_reset();
        nv = 1; v = 1'b0;
        for (int c = 0; c < 400 && rxq.size() < 20; c++) begin
            if (!v && nv <= 20) v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            acc = v && model_ready();
            step(v, nv, r);
            if (acc) begin
                nv++;
                v = 1'b0;
            end
        end
        check("wrap_rx_count", rxq.size(), 32'd20);
        for (int i = 0; i < 20 && i < rxq.size(); i++) check("wrap_order", rxq[i], 32'(i + 1));

        // Randomized traffic with random data on the 4-deep instance
        sel = 0; cap = 4;
        do_reset();
        v = 1'b0; nv = $urandom;
        for (int c = 0; c < 120; c++) begin
            if (!v) begin
                v  = ($urandom_range(0, 2) != 0);
                nv = $urandom;
            end
            r = ($urandom_range(0, 3) != 0);
            acc = v && model_ready();
            step(v, nv, r);
            if (acc) v = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
